// File: rtl/sequential_dwc_accumulator.sv
// Dual-redundant accumulator with lock-step compare, mismatch counting and a
// RUN/ERROR/LOCK supervisor. Copy 1 can be perturbed through port_inject for fault tests.
module sequential_dwc_accumulator #(
  parameter int WIDTH       = 8,
  parameter int CNT_WIDTH   = 4,
  parameter int LOCK_THRESH = 3
) (
  input  logic                 port_clk,
  input  logic                 port_rst,
  input  logic                 port_in_valid,
  input  logic [WIDTH-1:0]     port_in_data,
  input  logic [WIDTH-1:0]     port_inject,
  input  logic                 port_clear,
  output logic [WIDTH-1:0]     port_out,
  output logic                 port_out_valid,
  output logic                 port_error,
  output logic [WIDTH-1:0]     port_error_vec,
  output logic [CNT_WIDTH-1:0] port_error_count,
  output logic                 port_lock
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_ERROR = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LOCK_THRESH_C = CNT_WIDTH'(LOCK_THRESH);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == {CNT_WIDTH{1'b1}}) ? c : c + 1'b1;
  endfunction

  (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] acc0_p1;
  (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] acc1_p1;

  state_t               state_p1;
  logic [CNT_WIDTH-1:0] cnt_p1;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 vld_p1;
  logic                 lock_p1;

  assign cnt_inc = sat_inc(cnt_p1);

  // Stage p1: redundant accumulators and supervisor state, all updated on one edge.
  // A detected mismatch takes precedence over an accumulate on the same edge so
  // the diverged copies are frozen exactly as they were when the fault showed.
  always_ff @(posedge port_clk) begin
    if (port_rst) begin
      acc0_p1  <= '0;
      acc1_p1  <= '0;
      state_p1 <= S_RUN;
      cnt_p1   <= '0;
      vld_p1   <= 1'b0;
      lock_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      case (state_p1)
        S_RUN: begin
          if (port_clear) begin
            acc0_p1 <= '0;
            acc1_p1 <= '0;
          end else if (port_error) begin
            cnt_p1 <= cnt_inc;
            if (cnt_inc >= LOCK_THRESH_C) begin
              state_p1 <= S_LOCK;
              lock_p1  <= 1'b1;
            end else begin
              state_p1 <= S_ERROR;
            end
          end else if (port_in_valid) begin
            acc0_p1 <= acc0_p1 + port_in_data;
            acc1_p1 <= acc1_p1 + (port_in_data ^ port_inject);
            vld_p1  <= 1'b1;
          end
        end
        S_ERROR: begin
          if (port_clear) begin
            acc0_p1  <= '0;
            acc1_p1  <= '0;
            state_p1 <= S_RUN;
          end
        end
        S_LOCK: begin
          lock_p1 <= 1'b1;
        end
        default: begin
          state_p1 <= S_RUN;
          lock_p1  <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: compare is combinational on the registered copies.
  assign port_out         = acc0_p1;
  assign port_out_valid   = vld_p1;
  assign port_error_vec   = acc0_p1 ^ acc1_p1;
  assign port_error       = |port_error_vec;
  assign port_error_count = cnt_p1;
  assign port_lock        = lock_p1;

endmodule

// File: tb/tb_sequential_dwc_accumulator.sv
// Bench for sequential_dwc_accumulator: directed vector table, hand-written
// corner sequences and randomized traffic against a rule-level reference model.
module tb_sequential_dwc_accumulator;

  localparam int WIDTH       = 8;
  localparam int CNT_WIDTH   = 4;
  localparam int LOCK_THRESH = 3;
  localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic [WIDTH-1:0]     inject;
  logic                 clear;
  logic [WIDTH-1:0]     out;
  logic                 out_valid;
  logic                 error;
  logic [WIDTH-1:0]     error_vec;
  logic [CNT_WIDTH-1:0] error_count;
  logic                 lock;

  int n_checks = 0;
  int n_fail   = 0;

  sequential_dwc_accumulator #(
    .WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH), .LOCK_THRESH(LOCK_THRESH)
  ) dut (
    .port_clk(clk),
    .port_rst(rst),
    .port_in_valid(in_valid),
    .port_in_data(in_data),
    .port_inject(inject),
    .port_clear(clear),
    .port_out(out),
    .port_out_valid(out_valid),
    .port_error(error),
    .port_error_vec(error_vec),
    .port_error_count(error_count),
    .port_lock(lock)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=RUN 1=ERROR 2=LOCK, plain integer arithmetic.
  int m_acc0, m_acc1, m_mode, m_cnt;
  bit m_vld;

  function automatic bit m_err();
    return m_acc0 != m_acc1;
  endfunction

  task automatic model_step(input bit r, input bit v, input int d, input int inj, input bit c);
    bit mismatch;
    mismatch = m_err();
    m_vld = 1'b0;
    if (r) begin
      m_acc0 = 0; m_acc1 = 0; m_mode = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (c) begin
        m_acc0 = 0; m_acc1 = 0;
      end else if (mismatch) begin
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        m_mode = (m_cnt >= LOCK_THRESH) ? 2 : 1;
      end else if (v) begin
        m_acc0 = (m_acc0 + d) % 256;
        m_acc1 = (m_acc1 + (d ^ inj)) % 256;
        m_vld  = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (c) begin
        m_acc0 = 0; m_acc1 = 0; m_mode = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive after the falling edge, sample 1 ns after the rising edge.
  task automatic cycle(input bit r, input bit v, input int d, input int inj, input bit c);
    @(negedge clk);
    rst = r; in_valid = v; in_data = WIDTH'(d); inject = WIDTH'(inj); clear = c;
    @(posedge clk);
    #1;
    model_step(r, v, d, inj, c);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out"},       64'(out),         64'(m_acc0));
    check({tag, ".out_valid"}, 64'(out_valid),   64'(m_vld));
    check({tag, ".error_vec"}, 64'(error_vec),   64'(m_acc0 ^ m_acc1));
    check({tag, ".error"},     64'(error),       64'(m_err()));
    check({tag, ".count"},     64'(error_count), 64'(m_cnt));
    check({tag, ".lock"},      64'(lock),        64'(m_mode == 2));
  endtask

  typedef struct {
    bit r; bit v; int d; int inj; bit c;
    int e_out; bit e_vld; int e_vec; int e_cnt; bit e_lock;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; inject = '0; clear = 1'b0;
    m_acc0 = 0; m_acc1 = 0; m_mode = 0; m_cnt = 0; m_vld = 0;

    //         r  v  d     inj   c   out   vld vec   cnt lock
    tbl.push_back('{1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 8'h10, 8'h00, 0, 8'h10, 1, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 8'h20, 8'h00, 0, 8'h30, 1, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 8'hF0, 8'h00, 0, 8'h20, 1, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 8'h01, 8'h04, 0, 8'h21, 1, 8'h04, 0, 0});
    tbl.push_back('{0, 0, 8'h00, 8'h00, 0, 8'h21, 0, 8'h04, 1, 0});
    tbl.push_back('{0, 1, 8'h33, 8'h00, 0, 8'h21, 0, 8'h04, 1, 0});
    tbl.push_back('{0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 8'h00, 1, 0});
    tbl.push_back('{0, 1, 8'h05, 8'h00, 0, 8'h05, 1, 8'h00, 1, 0});
    tbl.push_back('{0, 1, 8'h01, 8'h01, 0, 8'h06, 1, 8'h03, 1, 0});
    tbl.push_back('{0, 0, 8'h00, 8'h00, 0, 8'h06, 0, 8'h03, 2, 0});
    tbl.push_back('{0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 8'h00, 2, 0});
    tbl.push_back('{0, 1, 8'h02, 8'h80, 0, 8'h02, 1, 8'h80, 2, 0});
    tbl.push_back('{0, 0, 8'h00, 8'h00, 0, 8'h02, 0, 8'h80, 3, 1});
    tbl.push_back('{0, 0, 8'h00, 8'h00, 1, 8'h02, 0, 8'h80, 3, 1});
    tbl.push_back('{0, 1, 8'h09, 8'h00, 0, 8'h02, 0, 8'h80, 3, 1});
    tbl.push_back('{1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 8'h07, 8'h00, 1, 8'h00, 0, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 8'h07, 8'h00, 0, 8'h07, 1, 8'h00, 0, 0});
    tbl.push_back('{1, 1, 8'h08, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0});

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      cycle(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].inj, tbl[i].c);
      check({tag, ".out"},       64'(out),         64'(tbl[i].e_out));
      check({tag, ".out_valid"}, 64'(out_valid),   64'(tbl[i].e_vld));
      check({tag, ".error_vec"}, 64'(error_vec),   64'(tbl[i].e_vec));
      check({tag, ".error"},     64'(error),       64'(tbl[i].e_vec != 0));
      check({tag, ".count"},     64'(error_count), 64'(tbl[i].e_cnt));
      check({tag, ".lock"},      64'(lock),        64'(tbl[i].e_lock));
    end

    // Clear on the same edge as a pending mismatch: no count, stays in RUN.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 8'h11, 8'h01, 0);
    check("prio.error_set", 64'(error), 64'd1);
    cycle(0, 0, 0, 0, 1);
    check("prio.count", 64'(error_count), 64'd0);
    check("prio.error", 64'(error), 64'd0);
    cycle(0, 1, 8'h0A, 8'h00, 0);
    check("prio.run_accum", 64'(out), 64'h0A);
    check("prio.run_vld", 64'(out_valid), 64'd1);

    // Reset while sitting in ERROR.
    cycle(0, 1, 8'h01, 8'h02, 0);
    cycle(0, 0, 0, 0, 0);
    check("err_rst.count_before", 64'(error_count), 64'd1);
    cycle(1, 1, 8'h05, 8'h00, 1);
    check_model("err_rst");
    check("err_rst.count", 64'(error_count), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit r, v, c;
      int d, inj;
      r   = ($urandom_range(0, 49) == 0);
      c   = ($urandom_range(0, 7) == 0);
      v   = $urandom_range(0, 1);
      d   = $urandom_range(0, 255);
      inj = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 255) : 0;
      if (m_mode == 0 && m_err()) v = 1'b0;
      cycle(r, v, d, inj, c);
      check_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sequential_dwc_accumulator.md
SEQUENTIAL_DWC_ACCUMULATOR -- requirements
Module: sequential_dwc_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data and accumulator width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 4, giving the mismatch-counter width in bits (legal range 1..16).
REQ-003 The block SHALL have parameter LOCK_THRESH, default 3, giving the mismatch count that forces LOCK (legal range 1..2^CNT_WIDTH-1).
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 port_clk  input  1  clock; all state updates on the rising edge.
REQ-006 port_rst  input  1  synchronous active-high reset.
REQ-007 port_in_valid  input  1  accumulate port_in_data this cycle.
REQ-008 port_in_data  input  WIDTH  operand added into both redundant copies.
REQ-009 port_inject  input  WIDTH  test-only fault mask, XORed into the copy-1 adder input only; tie to 0 in mission use.
REQ-010 port_clear  input  1  resynchronise: zero both copies and leave ERROR.
REQ-011 port_out  output  WIDTH  copy-0 accumulator value (registered).
REQ-012 port_out_valid  output  1  high one cycle after each accepted accumulate.
REQ-013 port_error  output  1  combinational OR of port_error_vec.
REQ-014 port_error_vec  output  WIDTH  combinational bitwise XOR of copy 0 and copy 1.
REQ-015 port_error_count  output  CNT_WIDTH  registered, saturating count of mismatch events.
REQ-016 port_lock  output  1  high while the FSM is in LOCK.

Function
REQ-017 The block SHALL hold two independent WIDTH-bit accumulators, acc0 and acc1, each with its own adder; synthesis SHALL NOT merge them (keep/dont_touch attribute on both).
REQ-018 When port_in_valid=1 in RUN, acc0 SHALL become acc0+port_in_data and acc1 SHALL become acc1+(port_in_data^port_inject), both modulo 2^WIDTH, so wrap-around is silent.
REQ-019 port_out SHALL equal acc0.
REQ-020 port_out_valid SHALL be a one-cycle registered copy of the accepted port_in_valid, and SHALL be 0 outside RUN.
REQ-021 The FSM SHALL have exactly the states RUN, ERROR and LOCK.
REQ-022 In RUN, if port_error=1 at a clock edge, the FSM SHALL go to ERROR and port_error_count SHALL increment by 1, saturating at 2^CNT_WIDTH-1.
REQ-023 In RUN, if port_error=1 and the incremented count is >= LOCK_THRESH, the FSM SHALL go directly to LOCK instead of ERROR.
REQ-024 In ERROR, port_in_valid SHALL be ignored, both accumulators SHALL hold, and the count SHALL NOT increment again.
REQ-025 In ERROR, port_clear=1 SHALL zero acc0 and acc1 and return the FSM to RUN on the next edge.
REQ-026 In RUN, port_clear=1 SHALL zero both accumulators; if asserted together with port_in_valid, clear SHALL win and the operand SHALL be dropped (port_out_valid=0 next cycle).
REQ-027 In RUN, port_clear SHALL take priority over mismatch detection on the same edge: no count increment and no state change.
REQ-028 LOCK SHALL be exited only by port_rst; in LOCK the block SHALL ignore port_in_valid and port_clear, and SHALL hold accumulators and count.
REQ-029 port_clear SHALL NOT reset port_error_count.

Reset
REQ-030 On port_rst=1 at a clock edge: acc0=acc1=0, FSM=RUN, port_error_count=0, port_out_valid=0, port_lock=0; hence port_out=0, port_error_vec=0, port_error=0.
REQ-031 Reset SHALL take priority over all other inputs, in every state, including mid-accumulate and LOCK.

Verification
REQ-032 WIDTH=8: reset, then accumulate 0x10, 0x20, 0xF0 with inject=0 -> port_out 0x10, 0x30, 0x20 (wrap); out_valid pulses each time; error stays 0; count 0.
REQ-033 Accumulate 0x01 with inject=0x04 -> next cycle error_vec=0x04, error=1; following edge state ERROR, count=1; later valid inputs ignored.
REQ-034 From ERROR assert port_clear -> next cycle port_out=0, error=0, state RUN, count stays 1; accumulate 0x05 -> port_out=0x05.
REQ-035 Three inject/clear cycles with LOCK_THRESH=3 -> count=3, port_lock=1 after the third mismatch; clear and valid are ignored; port_rst -> lock=0, count=0, out=0.
REQ-036 In RUN, assert port_in_valid=1 (data 0x07) and port_clear=1 together -> port_out=0, out_valid=0; assert port_rst during an accumulate -> all outputs 0 next cycle.
